// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder: width limit, parameter
// legality check and the per-stage register layout.
package adder_pkg;

  localparam int MAX_BITS = 64;

  function automatic bit params_legal(input int num_bits, input int num_stages);
    return (num_bits >= 2) && (num_bits <= MAX_BITS) &&
           (num_stages >= 1) && (num_stages <= num_bits) &&
           ((num_bits % num_stages) == 0);
  endfunction

  // Fields are sized for MAX_BITS; bits above NUM_BITS stay zero and are trimmed.
  typedef struct packed {
    logic                valid;
    logic [MAX_BITS-1:0] a_skew;
    logic [MAX_BITS-1:0] b_skew;
    logic [MAX_BITS-1:0] psum;
    logic                carry;
  } stage_t;

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit ripple-carry adder, one instance per pipeline stage.
module adder_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         carry_in,
  output logic [W-1:0] sum,
  output logic         carry_out
);

  logic [W:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = carry_in;
    for (int i = 0; i < W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    carry_out = c[W];
  end

endmodule

// File: rtl/adder_nbit_pipe.sv
// Pipelined NUM_BITS adder split into NUM_STAGES ripple slices with
// valid/ready flow control. Define ADDER_OVERFLOW_EN to get the signed overflow flag.
module adder_nbit_pipe
  import adder_pkg::*;
#(
  parameter int NUM_BITS   = 8,
  parameter int NUM_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                carry_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_BITS-1:0] sum,
  output logic                carry_out,
  output logic                overflow
);

  localparam int W = NUM_BITS / NUM_STAGES;

  if (!params_legal(NUM_BITS, NUM_STAGES)) begin : g_param_check
    $fatal(1, "adder_nbit_pipe: illegal NUM_BITS=%0d / NUM_STAGES=%0d", NUM_BITS, NUM_STAGES);
  end

  stage_t                stg_q [NUM_STAGES];
  logic [NUM_STAGES-1:0] stg_valid;
  logic [NUM_STAGES:0]   ready;

`ifdef ADDER_OVERFLOW_EN
  logic ovf_q;
`endif

  // A stage may load when empty or when the stage after it can take its contents.
  always_comb begin
    ready             = '0;
    ready[NUM_STAGES] = out_ready;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      ready[k] = ~stg_valid[k] | ready[k+1];
    end
  end

  assign in_ready = ready[0] & ~rst;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    stage_t       src;
    stage_t       d;
    stage_t       q;
    logic [W-1:0] sa;
    logic [W-1:0] sb;
    logic [W-1:0] ss;
    logic         sci;
    logic         sco;

    if (k == 0) begin : g_first
      always_comb begin
        src                       = '0;
        src.valid                 = in_valid;
        src.a_skew[NUM_BITS-1:0]  = a;
        src.b_skew[NUM_BITS-1:0]  = b;
        src.carry                 = carry_in;
      end
    end else begin : g_next
      assign src = stg_q[k-1];
    end

    assign sa  = src.a_skew[k*W +: W];
    assign sb  = src.b_skew[k*W +: W];
    assign sci = src.carry;

    adder_slice #(.W(W)) u_slice (
      .a        (sa),
      .b        (sb),
      .carry_in (sci),
      .sum      (ss),
      .carry_out(sco)
    );

    always_comb begin
      d                = src;
      d.psum[k*W +: W] = ss;
      d.carry          = sco;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        q <= '0;
      end else if (ready[k]) begin
        if (src.valid) q <= d;
        else           q.valid <= 1'b0;
      end
    end

    assign stg_q[k]     = q;
    assign stg_valid[k] = q.valid;

`ifdef ADDER_OVERFLOW_EN
    // Carry into the MSB is recovered from the MSB operand and sum bits.
    if (k == NUM_STAGES - 1) begin : g_ovf
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (ready[k] && src.valid) begin
          ovf_q <= sa[W-1] ^ sb[W-1] ^ ss[W-1] ^ sco;
        end
      end
    end
`endif
  end

  assign out_valid = stg_q[NUM_STAGES-1].valid;
  assign sum       = stg_q[NUM_STAGES-1].psum[NUM_BITS-1:0];
  assign carry_out = stg_q[NUM_STAGES-1].carry;

`ifdef ADDER_OVERFLOW_EN
  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  // Upper struct bits and the drained skew operands of the last stage go nowhere.
  logic unused_stage_bits;
  always_comb begin
    unused_stage_bits = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      unused_stage_bits = unused_stage_bits ^ (^stg_q[k]);
    end
  end

endmodule

// File: tb/tb_adder_nbit_pipe.sv
// Directed self-checking bench for adder_nbit_pipe: reset, latency, streaming,
// backpressure, mid-flight reset and a 16-bit depth sweep.
module tb_adder_nbit_pipe;

`ifdef ADDER_OVERFLOW_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       carry_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       carry_out;
  logic       overflow;

  logic        d_in_valid;
  logic [15:0] d_a;
  logic [15:0] d_b;
  logic        d_cin;
  logic        d_in_ready [3];
  logic        d_out_valid[3];
  logic [15:0] d_sum      [3];
  logic        d_cout     [3];
  logic        d_ovf      [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  adder_nbit_pipe #(.NUM_BITS(8), .NUM_STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .carry_in(carry_in), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .carry_out(carry_out), .overflow(overflow)
  );

  adder_nbit_pipe #(.NUM_BITS(16), .NUM_STAGES(1)) dut_s1 (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready[0]),
    .a(d_a), .b(d_b), .carry_in(d_cin), .out_valid(d_out_valid[0]),
    .out_ready(1'b1), .sum(d_sum[0]), .carry_out(d_cout[0]), .overflow(d_ovf[0])
  );

  adder_nbit_pipe #(.NUM_BITS(16), .NUM_STAGES(4)) dut_s4 (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready[1]),
    .a(d_a), .b(d_b), .carry_in(d_cin), .out_valid(d_out_valid[1]),
    .out_ready(1'b1), .sum(d_sum[1]), .carry_out(d_cout[1]), .overflow(d_ovf[1])
  );

  adder_nbit_pipe #(.NUM_BITS(16), .NUM_STAGES(16)) dut_s16 (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready[2]),
    .a(d_a), .b(d_b), .carry_in(d_cin), .out_valid(d_out_valid[2]),
    .out_ready(1'b1), .sum(d_sum[2]), .carry_out(d_cout[2]), .overflow(d_ovf[2])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; a = 8'hAA; b = 8'h55; carry_in = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (sum !== 8'h00) begin n_fail++; $display("FAIL reset_sum got %h want 00", sum); end
    n_checks++; if (carry_out !== 1'b0) begin n_fail++; $display("FAIL reset_carry got %b want 0", carry_out); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_no_accept got %b want 0", out_valid); end
  endtask

  task automatic test_basic();
    logic [7:0] va[2] = '{8'hFF, 8'h7F};
    logic [7:0] vb[2] = '{8'h01, 8'h01};
    logic [7:0] es[2] = '{8'h00, 8'h80};
    logic       ec[2] = '{1'b1, 1'b0};
    logic       eo[2] = '{1'b0, OVF_EN};
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; a = va[i]; b = vb[i]; carry_in = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic%0d_in_ready got %b want 1", i, in_ready); end
      tick();
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic%0d_early got %b want 0", i, out_valid); end
      tick();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic%0d_valid got %b want 1", i, out_valid); end
      n_checks++; if (sum !== es[i]) begin n_fail++; $display("FAIL basic%0d_sum got %h want %h", i, sum, es[i]); end
      n_checks++; if (carry_out !== ec[i]) begin n_fail++; $display("FAIL basic%0d_carry got %b want %b", i, carry_out, ec[i]); end
      n_checks++; if (overflow !== eo[i]) begin n_fail++; $display("FAIL basic%0d_ovf got %b want %b", i, overflow, eo[i]); end
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic%0d_drain got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] va[4] = '{8'h10, 8'h33, 8'h80, 8'hFE};
    logic [7:0] vb[4] = '{8'h20, 8'h44, 8'h80, 8'h01};
    logic       vc[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] es[4] = '{8'h30, 8'h77, 8'h00, 8'h00};
    logic       ec[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       eo[4] = '{1'b0, 1'b0, OVF_EN, 1'b0};
    out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c >= 2 && c < 6) begin
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b%0d_valid got %b want 1", c-2, out_valid); end
        n_checks++; if (sum !== es[c-2]) begin n_fail++; $display("FAIL b2b%0d_sum got %h want %h", c-2, sum, es[c-2]); end
        n_checks++; if (carry_out !== ec[c-2]) begin n_fail++; $display("FAIL b2b%0d_carry got %b want %b", c-2, carry_out, ec[c-2]); end
        n_checks++; if (overflow !== eo[c-2]) begin n_fail++; $display("FAIL b2b%0d_ovf got %b want %b", c-2, overflow, eo[c-2]); end
      end else begin
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_c%0d got %b want 0", c, out_valid); end
      end
      if (c < 4) begin
        in_valid = 1'b1; a = va[c]; b = vb[c]; carry_in = vc[c];
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b%0d_in_ready got %b want 1", c, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] va[3] = '{8'h01, 8'hF0, 8'h55};
    logic [7:0] vb[3] = '{8'h02, 8'h20, 8'h0A};
    logic       vc[3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] es[3] = '{8'h03, 8'h10, 8'h60};
    logic       ec[3] = '{1'b0, 1'b1, 1'b0};
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; a = va[i]; b = vb[i]; carry_in = vc[i];
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_fill%0d_in_ready got %b want 1", i, in_ready); end
      tick();
    end
    in_valid = 1'b1; a = va[2]; b = vb[2]; carry_in = vc[2];
    for (int s = 0; s < 3; s++) begin
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall%0d_in_ready got %b want 0", s, in_ready); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_stall%0d_valid got %b want 1", s, out_valid); end
      n_checks++; if (sum !== es[0]) begin n_fail++; $display("FAIL bp_stall%0d_sum got %h want %h", s, sum, es[0]); end
      n_checks++; if (carry_out !== ec[0]) begin n_fail++; $display("FAIL bp_stall%0d_carry got %b want %b", s, carry_out, ec[0]); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
    for (int r = 0; r < 3; r++) begin
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out%0d_valid got %b want 1", r, out_valid); end
      n_checks++; if (sum !== es[r]) begin n_fail++; $display("FAIL bp_out%0d_sum got %h want %h", r, sum, es[r]); end
      n_checks++; if (carry_out !== ec[r]) begin n_fail++; $display("FAIL bp_out%0d_carry got %b want %b", r, carry_out, ec[r]); end
      tick();
      in_valid = 1'b0;
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b want 0", out_valid); end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    in_valid = 1'b1; a = 8'h12; b = 8'h34; carry_in = 1'b0;
    tick();
    rst = 1'b1; a = 8'h99; b = 8'h11;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready got %b want 0", in_ready); end
    tick();
    rst = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_c%0d_valid got %b want 0", c, out_valid); end
      tick();
    end
  endtask

  task automatic test_depth_sweep();
    localparam int N = 8;
    int          depth[3] = '{1, 4, 16};
    logic [15:0] va[N];
    logic [15:0] vb[N];
    logic        vc[N];
    logic [16:0] ex[N];
    int          idx;
    for (int i = 0; i < N; i++) begin
      va[i] = 16'($urandom);
      vb[i] = 16'($urandom);
      vc[i] = 1'($urandom_range(0, 1));
    end
    va[0] = 16'hFFFF; vb[0] = 16'h0000; vc[0] = 1'b1;
    for (int i = 0; i < N; i++) ex[i] = {1'b0, va[i]} + {1'b0, vb[i]} + {16'h0000, vc[i]};
    for (int c = 0; c < N + 17; c++) begin
      for (int j = 0; j < 3; j++) begin
        idx = c - depth[j];
        if (idx >= 0 && idx < N) begin
          n_checks++; if (d_out_valid[j] !== 1'b1) begin n_fail++; $display("FAIL sweep_s%0d_r%0d_valid got %b want 1", depth[j], idx, d_out_valid[j]); end
          n_checks++; if ({d_cout[j], d_sum[j]} !== ex[idx]) begin n_fail++; $display("FAIL sweep_s%0d_r%0d_result got %h want %h", depth[j], idx, {d_cout[j], d_sum[j]}, ex[idx]); end
        end else begin
          n_checks++; if (d_out_valid[j] !== 1'b0) begin n_fail++; $display("FAIL sweep_s%0d_c%0d_idle got %b want 0", depth[j], c, d_out_valid[j]); end
        end
      end
      if (c < N) begin
        d_in_valid = 1'b1; d_a = va[c]; d_b = vb[c]; d_cin = vc[c];
        #1;
        for (int j = 0; j < 3; j++) begin
          n_checks++; if (d_in_ready[j] !== 1'b1) begin n_fail++; $display("FAIL sweep_s%0d_in_ready got %b want 1", depth[j], d_in_ready[j]); end
        end
      end else begin
        d_in_valid = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; out_ready = 1'b0;
    d_in_valid = 1'b0; d_a = '0; d_b = '0; d_cin = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_depth_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
